// File: rtl/fetch_controller_pkg.sv
// -----------------------------------------------------------------------------
// fetch_controller_pkg
// Shared encodings for the instruction-fetch controller.
//   fstate_e     : fetch FSM state encoding (2-bit)
//   halt_cause_e : sticky halt cause codes reported on halt_cause_o
//   pc_inc       : sequential PC advance (64-bit, carry dropped)
//   pc_misaligned: non-zero low address bits of an instruction PC
// -----------------------------------------------------------------------------
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        FSTATE_FETCH = 2'd0,
        FSTATE_VALID = 2'd1,
        FSTATE_HALT  = 2'd2
    } fstate_e;

    typedef enum logic [1:0] {
        HALT_NONE     = 2'd0,
        HALT_IMEM     = 2'd1,
        HALT_MISALIGN = 2'd2,
        HALT_TIMEOUT  = 2'd3
    } halt_cause_e;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    // Modulo 2^64 increment: the carry out of bit 63 is simply dropped.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 64'd4;
    endfunction

    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// Counts request cycles that have gone without a memory response.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, clears the count
//   clr_i     : clear the count (takes priority over en_i)
//   en_i      : advance the count by one
//   expired_o : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= 8'd0;
        end else if (en_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer. Owns the architectural PC, issues requests to a
// variable-latency instruction memory and hands the returned word to decode.
// Any fault (access error, misaligned PC, response timeout) latches a sticky
// halt that only reset clears.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   stall_i            : decode cannot accept, hold the current instruction
//   redirect_i/_pc_i   : branch/jump redirect and its target
//   imem_req_o/addr_o  : registered request level and fetch address (== pc_o)
//   imem_ack_i/instr_i : response valid and instruction word
//   imem_error_i       : access fault, qualified by imem_ack_i
//   instr_valid_o      : instr_o/pc_o hold a fetched instruction
//   instr_o, pc_o      : latched instruction and current PC
//   halt_o, halt_cause_o : sticky halt and its cause code
// -----------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_error_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        halt_o,
    output logic [1:0]  halt_cause_o
);

    fstate_e     state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    halt_cause_e cause_q, cause_d;
    logic        req_q, req_d;
    logic        cnt_clr, cnt_en, cnt_expired;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FSTATE_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cause_q <= HALT_NONE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cause_q <= cause_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cause_d = cause_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;

        unique case (state_q)
            FSTATE_FETCH: begin
                if (redirect_i) begin
                    // Any response arriving with the redirect belongs to the
                    // abandoned address and is dropped.
                    pc_d = redirect_pc_i;
                end else if (pc_misaligned(pc_q)) begin
                    state_d = FSTATE_HALT;
                    cause_d = HALT_MISALIGN;
                end else if (req_q) begin
                    // req_q is low only in the idle cycle right after reset,
                    // when no request is outstanding yet.
                    if (imem_ack_i && imem_error_i) begin
                        state_d = FSTATE_HALT;
                        cause_d = HALT_IMEM;
                    end else if (imem_ack_i) begin
                        instr_d = imem_instr_i;
                        state_d = FSTATE_VALID;
                    end else if (cnt_expired) begin
                        state_d = FSTATE_HALT;
                        cause_d = HALT_TIMEOUT;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_en  = 1'b1;
                    end
                end
            end
            FSTATE_VALID: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = FSTATE_FETCH;
                end else if (!stall_i) begin
                    pc_d    = pc_inc(pc_q);
                    state_d = FSTATE_FETCH;
                end
            end
            FSTATE_HALT: begin
                // Sticky: only reset leaves this state.
            end
            default: begin
                state_d = FSTATE_FETCH;
            end
        endcase

        // The request is registered from the next PC, so a misaligned PC never
        // reaches memory: it is caught in its FETCH cycle with req low.
        req_d = (state_d == FSTATE_FETCH) && !pc_misaligned(pc_d);
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == FSTATE_VALID);
    assign halt_o        = (state_q == FSTATE_HALT);
    assign halt_cause_o  = cause_q;

endmodule
